// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types and constants for the unified memory port arbiter.
//   arb_state_t    : arbiter sequencing states (IDLE -> BUSY -> DONE)
//   grant_t        : which pipeline stage owns the memory port
//   ARB_FAULT_WORD : read data substituted when an access times out
//   pick_grant()   : round-robin choice between the two requesters
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    localparam logic [31:0] ARB_FAULT_WORD = 32'hDEAD_BEEF;

    // On a tie the side that was not served last wins; otherwise the
    // single active requester wins. Only meaningful when a request is up.
    function automatic grant_t pick_grant(input logic   if_req,
                                          input logic   mem_req,
                                          input grant_t last_grant);
        if (if_req && mem_req)
            return (last_grant == GRANT_IF) ? GRANT_MEM : GRANT_IF;
        else if (mem_req)
            return GRANT_MEM;
        else
            return GRANT_IF;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog
// Counts cycles spent waiting on the memory and flags the last allowed one.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart the count from zero
//   enable   : count this cycle
//   expired  : current cycle is the final one (count == TIMEOUT-1)
module arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST  = W'(TIMEOUT - 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] count;

    // Saturating counter: parks at TIMEOUT instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && (count != LIMIT))
            count <= count + 1'b1;
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between instruction fetch (IF) and the
// load/store stage (MEM). Round-robin arbitration, one req/ack access at a
// time, read data returned to the owning side, watchdog abort on hung memory.
//   if_req/if_addr          -> if_rdata, if_done       fetch side
//   mem_req/we/addr/wdata   -> mem_rdata, mem_done     load/store side
//   ram_req/we/addr/wdata   <- ram_ack, ram_rdata      memory side
//   err                                                 sticky watchdog flag
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              err
);

    arb_state_t state, next_state;
    grant_t     granted, last_grant, pick;
    logic       any_req, finish, abort, wdog_expired;

    assign any_req = if_req | mem_req;
    assign pick    = pick_grant(if_req, mem_req, last_grant);
    assign finish  = (state == ARB_BUSY) && ram_ack;
    assign abort   = (state == ARB_BUSY) && !ram_ack && wdog_expired;

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ARB_IDLE),
        .enable  (state == ARB_BUSY),
        .expired (wdog_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ARB_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: if (any_req) next_state = ARB_BUSY;
            ARB_BUSY: if (finish || abort) next_state = ARB_DONE;
            ARB_DONE: next_state = ARB_IDLE;
            default:  next_state = ARB_IDLE;
        endcase
    end

    // Done pulses come straight from the DONE state so they can never overlap.
    always_comb begin
        if_done  = 1'b0;
        mem_done = 1'b0;
        if (state == ARB_DONE) begin
            if_done  = (granted == GRANT_IF);
            mem_done = (granted == GRANT_MEM);
        end
    end

    // Memory request registers: loaded on grant, held for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            granted   <= GRANT_IF;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if ((state == ARB_IDLE) && any_req) begin
            granted   <= pick;
            ram_req   <= 1'b1;
            ram_we    <= (pick == GRANT_MEM) ? mem_we : 1'b0;
            ram_addr  <= (pick == GRANT_MEM) ? mem_addr : if_addr;
            ram_wdata <= (pick == GRANT_MEM) ? mem_wdata : '0;
        end else if (finish || abort) begin
            ram_req   <= 1'b0;
        end
    end

    // Reset value MEM makes IF win the very first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= GRANT_MEM;
        else if (state == ARB_DONE)
            last_grant <= granted;
    end

    // Read data goes to the owning side; stores leave mem_rdata alone.
    // A timed-out read returns the fault word so the pipeline sees garbage it can spot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else if (finish || abort) begin
            if (granted == GRANT_IF)
                if_rdata <= finish ? ram_rdata : DATA_W'(ARB_FAULT_WORD);
            else if (!ram_we)
                mem_rdata <= finish ? ram_rdata : DATA_W'(ARB_FAULT_WORD);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (abort)
            err <= 1'b1;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared against a transaction-level reference of the arbiter kept here.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, ram_ack;
    logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
    logic        if_done, mem_done, ram_req, ram_we, err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata), .err(err)
    );

    int assertCount = 0;
    int failCount   = 0;

    // Reference: where the current access is in its life (0 waiting for a
    // request, 1 at the memory, 2 reporting completion) plus what it carries.
    int          stage;
    int          busyCycles;
    bit          who;
    bit          lastServed;
    bit          expWe, expErr;
    logic [31:0] expAddr, expWdata, expIfRdata, expMemRdata;
    int          ifDoneCount, memDoneCount;
    bit          doneOrder[$];
    logic [31:0] memArray [logic [31:0]];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] readMem(input logic [31:0] a);
        if (memArray.exists(a))
            return memArray[a];
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic resetModel();
        stage       = 0;
        busyCycles  = 0;
        who         = 1'b0;
        lastServed  = 1'b1;
        expWe       = 1'b0;
        expErr      = 1'b0;
        expAddr     = '0;
        expWdata    = '0;
        expIfRdata  = '0;
        expMemRdata = '0;
    endtask

    task automatic modelStep(input bit ir, input logic [31:0] ia, input bit mr,
                             input bit mw, input logic [31:0] ma, input logic [31:0] md,
                             input bit ack, input logic [31:0] rd);
        case (stage)
            0: if (ir || mr) begin
                who        = (ir && mr) ? !lastServed : mr;
                expWe      = who ? mw : 1'b0;
                expAddr    = who ? ma : ia;
                expWdata   = md;
                busyCycles = 0;
                stage      = 1;
            end
            1: begin
                if (ack || busyCycles == TO - 1) begin
                    if (!ack) expErr = 1'b1;
                    if (!who) expIfRdata = ack ? rd : 32'hDEADBEEF;
                    else if (!expWe) expMemRdata = ack ? rd : 32'hDEADBEEF;
                    stage = 2;
                end else begin
                    busyCycles++;
                end
            end
            default: begin
                lastServed = who;
                stage      = 0;
            end
        endcase
    endtask

    task automatic checkAll();
        checkOutput("ram_req", ram_req, stage == 1);
        if (stage == 1) begin
            checkOutput("ram_we", ram_we, expWe);
            checkOutput("ram_addr", ram_addr, expAddr);
            if (expWe) checkOutput("ram_wdata", ram_wdata, expWdata);
        end
        checkOutput("if_done", if_done, stage == 2 && !who);
        checkOutput("mem_done", mem_done, stage == 2 && who);
        checkOutput("if_rdata", if_rdata, expIfRdata);
        checkOutput("mem_rdata", mem_rdata, expMemRdata);
        checkOutput("err", err, expErr);
        if (if_done)  begin ifDoneCount++;  doneOrder.push_back(1'b0); end
        if (mem_done) begin memDoneCount++; doneOrder.push_back(1'b1); end
    endtask

    // Drive one cycle of inputs, let the edge happen, then check mid-cycle.
    task automatic applyStimulus(input bit ir, input logic [31:0] ia, input bit mr,
                                 input bit mw, input logic [31:0] ma, input logic [31:0] md,
                                 input bit ack, input logic [31:0] rd);
        if_req = ir; if_addr = ia;
        mem_req = mr; mem_we = mw; mem_addr = ma; mem_wdata = md;
        ram_ack = ack; ram_rdata = rd;
        @(posedge clk);
        modelStep(ir, ia, mr, mw, ma, md, ack, rd);
        @(negedge clk);
        checkAll();
    endtask

    task automatic idleInputs();
        if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
        mem_addr = 0; mem_wdata = 0; ram_ack = 0; ram_rdata = 0;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        resetModel();
        @(negedge clk);
        checkAll();
        rst = 1'b0;
    endtask

    initial begin
        int          reqHighCycles;
        int          doneBefore;
        bit          ack, ir, mr, mw;
        logic [31:0] ia, ma, md, rd;

        idleInputs();
        rst = 1'b1;
        resetModel();
        ifDoneCount = 0;
        memDoneCount = 0;
        repeat (2) @(negedge clk);
        $display("[TB] reset state");
        checkAll();
        rst = 1'b0;

        $display("[TB] IF only");
        repeat (3) applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 1, 32'h2402000A);
        checkOutput("t2_done_cycle5", if_done, 1);
        checkOutput("t2_if_rdata", if_rdata, 32'h2402000A);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_rdata_held", if_rdata, 32'h2402000A);

        $display("[TB] MEM store");
        memDoneCount = 0;
        applyStimulus(0, 0, 1, 1, 32'h100, 32'hCAFEF00D, 0, 0);
        checkOutput("t4_ram_we", ram_we, 1);
        checkOutput("t4_ram_addr", ram_addr, 32'h100);
        checkOutput("t4_ram_wdata", ram_wdata, 32'hCAFEF00D);
        repeat (2) applyStimulus(0, 0, 1, 1, 32'h100, 32'hCAFEF00D, 0, 0);
        applyStimulus(0, 0, 1, 1, 32'h100, 32'hCAFEF00D, 1, 32'h11111111);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_mem_done_once", memDoneCount, 1);
        checkOutput("t4_mem_rdata_kept", mem_rdata, 0);

        $display("[TB] contention");
        doReset();
        doneOrder.delete();
        repeat (30) begin
            ack = (stage == 1 && busyCycles == 1);
            applyStimulus(1, 32'h44, 1, 0, 32'h204, 0, ack, ack ? readMem(expAddr) : 32'h0);
        end
        checkOutput("t3_enough_grants", doneOrder.size() >= 4, 1);
        for (int k = 0; k < doneOrder.size(); k++)
            checkOutput($sformatf("t3_grant%0d", k), doneOrder[k], k % 2);
        repeat (8) begin
            ack = (stage == 1);
            applyStimulus(0, 0, 0, 0, 0, 0, ack, ack ? readMem(expAddr) : 32'h0);
        end

        $display("[TB] stray acks");
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1, $urandom);
        applyStimulus(1, 32'h48, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h48, 0, 0, 0, 0, 1, readMem(32'h48));
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1, $urandom);
        checkOutput("t6_if_rdata", if_rdata, readMem(32'h48));

        $display("[TB] timeout");
        memDoneCount = 0;
        reqHighCycles = 0;
        applyStimulus(0, 0, 1, 0, 32'h200, 0, 0, 0);
        repeat (8) begin
            if (ram_req) reqHighCycles++;
            applyStimulus(0, 0, memDoneCount == 0, 0, 32'h200, 0, 0, 0);
        end
        checkOutput("t5_busy_cycles", reqHighCycles, TO);
        checkOutput("t5_err", err, 1);
        checkOutput("t5_fault_word", mem_rdata, 32'hDEADBEEF);
        checkOutput("t5_mem_done_once", memDoneCount, 1);
        applyStimulus(1, 32'h4C, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h4C, 0, 0, 0, 0, 1, 32'h0BADF00D);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_err_sticky", err, 1);

        $display("[TB] reset mid-access");
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0);
        doneBefore = ifDoneCount;
        #2 rst = 1'b1;
        #1;
        checkOutput("t1_ram_req", ram_req, 0);
        checkOutput("t1_ram_we", ram_we, 0);
        checkOutput("t1_ram_addr", ram_addr, 0);
        checkOutput("t1_ram_wdata", ram_wdata, 0);
        checkOutput("t1_err", err, 0);
        checkOutput("t1_mem_rdata", mem_rdata, 0);
        checkOutput("t1_if_rdata", if_rdata, 0);
        checkOutput("t1_dones", {if_done, mem_done}, 0);
        idleInputs();
        resetModel();
        @(negedge clk);
        checkAll();
        rst = 1'b0;
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_no_done", ifDoneCount, doneBefore);

        $display("[TB] random traffic");
        ir = 0; mr = 0; mw = 0; ia = 0; ma = 0; md = 0;
        repeat (3000) begin
            if (if_done) begin
                ir = $urandom_range(0, 1);
                ia = 32'($urandom_range(0, 15)) << 2;
            end else if (!ir && $urandom_range(0, 3) == 0) begin
                ir = 1;
                ia = 32'($urandom_range(0, 15)) << 2;
            end else if (ir && stage == 1 && !who && $urandom_range(0, 15) == 0) begin
                ir = 0;
            end
            if (mem_done) begin
                mr = $urandom_range(0, 1);
                mw = $urandom_range(0, 1);
                ma = 32'($urandom_range(0, 15)) << 2;
                md = $urandom;
            end else if (!mr && $urandom_range(0, 3) == 0) begin
                mr = 1;
                mw = $urandom_range(0, 1);
                ma = 32'($urandom_range(0, 15)) << 2;
                md = $urandom;
            end else if (mr && stage == 1 && who && $urandom_range(0, 15) == 0) begin
                mr = 0;
            end
            if (stage == 1) begin
                ack = $urandom_range(0, 1);
                rd  = readMem(expAddr);
                if (ack && expWe) memArray[expAddr] = expWdata;
            end else begin
                ack = ($urandom_range(0, 3) == 0);
                rd  = $urandom;
            end
            applyStimulus(ir, ia, mr, mw, ma, md, ack, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
